dac_spi_tx: RTL and testbench
=============================

# dac_spi_tx

Serial transmitter that takes 16-bit audio samples from the tone/waveform generators and shifts them out to the board's SPI-style audio DAC. It sits between the sample producers (square-wave and drum-hit generators) and the DAC pins. It holds a one-sample buffer so a producer can hand over the next sample while the current frame is still shifting. It generates the serial clock, the frame-sync and the serial data lines itself.

## Interface
- `CLK_DIV`, default 2: `clk` cycles per `dac_sclk` half-period (≥1).
- `GAP_CYCLES`, default 4: `clk` cycles with `dac_sync_n` high between frames (≥1).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset; one clock; clears all state immediately.
- `data_in` in 16: sample word, sent MSB first.
- `data_valid` in 1: producer has a sample on `data_in`.
- `data_ready` out 1: holding register empty; transfer occurs on a rising edge with `data_valid & data_ready`.
- `dac_sclk` out 1: serial clock, idles high.
- `dac_sync_n` out 1: frame sync, active low during the 16 bits.
- `dac_sdata` out 1: serial data.
- `frame_done` out 1: one-cycle pulse on the cycle `dac_sync_n` returns high.

## Operation
- Holding register `hold` with flag `hold_full`.
  - `data_ready = ~hold_full`, driven combinationally from the register.
  - On a transfer, `hold <= data_in` and `hold_full <= 1`.
- FSM states: IDLE, SHIFT, GAP.
- **IDLE**
  - Outputs: `dac_sync_n=1`, `dac_sclk=1`, `dac_sdata=0`.
  - If `hold_full`: load `hold` into the 16-bit shifter, clear `hold_full`, set `dac_sync_n=0`, put bit 15 on `dac_sdata`, go to SHIFT.
- **SHIFT**
  - Each bit lasts 2·`CLK_DIV` cycles: `dac_sclk` is high for `CLK_DIV` cycles, then low for `CLK_DIV` cycles.
  - The DAC samples on the falling edge, mid-bit.
  - On each low→high `dac_sclk` transition, shift and present the next bit.
  - A 4-bit bit counter tracks 15→0. After the low half of bit 0: `dac_sclk=1`, `dac_sync_n=1`, `dac_sdata=0`, pulse `frame_done`, go to GAP.
- **GAP**
  - Count `GAP_CYCLES` cycles, including the `frame_done` cycle.
  - At the end: if `hold_full`, load as in IDLE and go straight to SHIFT; otherwise go to IDLE.
- `hold` may be refilled at any time it is empty, including during SHIFT/GAP.
- Simultaneous events:
  - If `hold` is moving to the shifter on a cycle, `data_ready` is still low on that cycle (old `hold_full=1`). It goes high the next cycle.
  - No sample is accepted and loaded on the same edge.
- Underrun: no sample at the end of GAP → IDLE. Lines stay idle and no sample is repeated.
- Reset values: `dac_sclk=1`, `dac_sync_n=1`, `dac_sdata=0`, `frame_done=0`, `data_ready=1`, state IDLE, counters 0.
- Reset asserted mid-frame aborts the frame immediately (lines go idle asynchronously) and discards both the held and the shifting sample.

## Timing
- Acceptance edge T (FSM idle) → `hold_full=1` after T → load edge T+1 → `dac_sync_n` low and bit 15 valid after T+1.
- Frame: `dac_sync_n` low for 32·`CLK_DIV` cycles (64 at default).
- Frame period with continuous supply: 32·`CLK_DIV` + `GAP_CYCLES` cycles (68 at default).
- First `dac_sclk` falling edge occurs `CLK_DIV` cycles after `dac_sync_n` falls.
- `dac_sdata` changes only with `dac_sclk` rising, or with a `dac_sync_n` edge.
- All outputs are registered except `data_ready`.

## Structure
- Shared audio package holds:
  - the state typedef (IDLE/SHIFT/GAP);
  - `SAMPLE_W = 16`;
  - the default `CLK_DIV`/`GAP_CYCLES` constants, so generators and this block agree on sample width.
- One sub-module: `sclk_tick_gen`. It is a `CLK_DIV` down-counter that emits a half-period tick and is enabled only in SHIFT.

## Test plan
- Single sample 0xA5C3 after reset, `CLK_DIV=2`:
  - `dac_sync_n` low 64 cycles, starting one cycle after acceptance.
  - Bits captured on `dac_sclk` falling edges read 1010_0101_1100_0011.
  - `frame_done` pulses once, then lines go idle.
- Continuous `data_valid` with 0x1FFF, 0x0000, 0x1FFF:
  - `dac_sync_n` falling edges exactly 68 cycles apart.
  - `data_ready` low while `hold` is full.
  - Three frames with the correct words.
- Second sample presented during SHIFT of the first:
  - accepted immediately (`data_ready=1`);
  - sent right after GAP with no IDLE cycle.
- Underrun: one sample only → after GAP, state IDLE, `dac_sclk=1`, `dac_sync_n=1`, `dac_sdata=0` indefinitely, with no repeated frame.
- `reset` pulsed at bit 7 of a frame with `hold` full:
  - outputs idle within the reset cycle;
  - `data_ready=1`;
  - after release, no frame until a new sample arrives.
- `CLK_DIV=1`, `GAP_CYCLES=1`, sample 0x8001:
  - `dac_sync_n` low 32 cycles;
  - `dac_sclk` toggles every cycle;
  - first and last captured bits are 1.

Source files
------------

// File: rtl/dac_spi_tx_pkg.sv
// Shared audio definitions: sample width, default serial timing and the
// transmitter state encoding, so sample producers and the DAC link agree.
// Ports: none (package).
package dac_spi_tx_pkg;

  // Width of one audio sample as produced by the tone/drum generators.
  localparam int SAMPLE_W       = 16;

  // Bit counter width, enough to index SAMPLE_W-1 down to 0.
  localparam int BIT_CNT_W      = 4;

  // Default serial timing: clk cycles per sclk half-period and the idle
  // gap between frames.
  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_GAP_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  // Counter width for a down-counter that must hold n-1; never narrower
  // than one bit so n == 1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dac_spi_tx_sclk_tick_gen.sv
// Purpose: half-period tick generator for the DAC serial clock.
// Latency: first tick CLK_DIV cycles after i_en rises, then every CLK_DIV cycles.
// Backpressure: none; i_en low holds the counter at its reload value.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   i_en       : count enable (high only while a frame is shifting)
//   o_tick     : one-cycle pulse marking the end of an sclk half-period
module sclk_tick_gen
  import dac_spi_tx_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_tick
);

  localparam int            CW     = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Reset leaves the counter at zero; the FSM always spends at least one
  // disabled cycle before shifting, which reloads it, so the first half
  // period of every frame is a full CLK_DIV cycles long.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_en || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/dac_spi_tx.sv
// Purpose: serialise 16-bit audio samples MSB first onto an SPI-style DAC link.
// Latency: accept edge T, frame starts (sync low, bit 15 on sdata) after edge T+1.
// Backpressure: one-sample holding register; data_ready low while it is full.
// Ports:
//   clk, reset   : system clock, asynchronous active-high reset
//   data_in      : sample word, sent MSB first
//   data_valid   : producer offers data_in
//   data_ready   : holding register empty (combinational from a register)
//   dac_sclk     : serial clock, idles high, DAC samples on its falling edge
//   dac_sync_n   : frame sync, low for the 16 bits of a frame
//   dac_sdata    : serial data, changes on sclk rising or sync edges only
//   frame_done   : one-cycle pulse on the cycle dac_sync_n returns high
module dac_spi_tx
  import dac_spi_tx_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                dac_sclk,
  output logic                dac_sync_n,
  output logic                dac_sdata,
  output logic                frame_done
);

  localparam int                   GW        = cnt_width(GAP_CYCLES);
  localparam logic [GW-1:0]        GAP_LOAD  = GW'(GAP_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] FIRST_BIT = BIT_CNT_W'(SAMPLE_W - 1);

  tx_state_t r_state, w_state_nxt;

  logic [SAMPLE_W-1:0]  r_hold;
  logic                 r_hold_full, w_hold_full_nxt;
  logic [SAMPLE_W-1:0]  r_shift, w_shift_nxt;
  logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [GW-1:0]        r_gap_cnt, w_gap_cnt_nxt;

  logic r_sclk, w_sclk_nxt;
  logic r_sync_n, w_sync_n_nxt;
  logic r_sdata, w_sdata_nxt;
  logic r_frame_done, w_frame_done_nxt;

  logic w_accept;
  logic w_load;
  logic w_tick;

  // Accept only into an empty holding register; a load empties it, so an
  // accept and a load can never fall on the same edge.
  assign w_accept   = data_valid && !r_hold_full;
  assign data_ready = !r_hold_full;

  sclk_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .i_en   (r_state == SHIFT),
    .o_tick (w_tick)
  );

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_sclk_nxt       = r_sclk;
    w_sync_n_nxt     = r_sync_n;
    w_sdata_nxt      = r_sdata;
    w_frame_done_nxt = 1'b0;
    w_load           = 1'b0;

    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_load = 1'b1;
        end
      end

      SHIFT: begin
        if (w_tick) begin
          if (r_sclk) begin
            // End of the high half: falling edge, DAC samples mid-bit.
            w_sclk_nxt = 1'b0;
          end else if (r_bit_cnt == '0) begin
            // End of the low half of the last bit: close the frame.
            w_sclk_nxt       = 1'b1;
            w_sync_n_nxt     = 1'b1;
            w_sdata_nxt      = 1'b0;
            w_frame_done_nxt = 1'b1;
            w_gap_cnt_nxt    = GAP_LOAD;
            w_state_nxt      = GAP;
          end else begin
            // Rising edge: move on to the next bit.
            w_sclk_nxt    = 1'b1;
            w_shift_nxt   = r_shift << 1;
            w_sdata_nxt   = r_shift[SAMPLE_W-2];
            w_bit_cnt_nxt = r_bit_cnt - 1'b1;
          end
        end
      end

      GAP: begin
        // The frame_done cycle is the first of the GAP_CYCLES gap cycles.
        if (r_gap_cnt == '0) begin
          if (r_hold_full) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Frame start, shared by IDLE and the end of GAP.
    if (w_load) begin
      w_shift_nxt   = r_hold;
      w_bit_cnt_nxt = FIRST_BIT;
      w_sclk_nxt    = 1'b1;
      w_sync_n_nxt  = 1'b0;
      w_sdata_nxt   = r_hold[SAMPLE_W-1];
      w_state_nxt   = SHIFT;
    end

    w_hold_full_nxt = r_hold_full;
    if (w_load) begin
      w_hold_full_nxt = 1'b0;
    end else if (w_accept) begin
      w_hold_full_nxt = 1'b1;
    end
  end

  // State and output registers; reset forces the lines idle immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_hold_full  <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_sclk       <= 1'b1;
      r_sync_n     <= 1'b1;
      r_sdata      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_full  <= w_hold_full_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_sclk       <= w_sclk_nxt;
      r_sync_n     <= w_sync_n_nxt;
      r_sdata      <= w_sdata_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Holding register data; only its flag matters for control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
    end else if (w_accept) begin
      r_hold <= data_in;
    end
  end

  assign dac_sclk   = r_sclk;
  assign dac_sync_n = r_sync_n;
  assign dac_sdata  = r_sdata;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Purpose: directed self-checking bench for dac_spi_tx (default timing and
// CLK_DIV=1/GAP_CYCLES=1 instances).
// Ports: none.
module tb_dac_spi_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready, dac_sclk, dac_sync_n, dac_sdata, frame_done;

  logic [15:0] data_in1 = '0;
  logic        data_valid1 = 1'b0;
  logic        data_ready1, dac_sclk1, dac_sync_n1, dac_sdata1, frame_done1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dac_spi_tx #(.CLK_DIV(2), .GAP_CYCLES(4)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .dac_sclk   (dac_sclk),
    .dac_sync_n (dac_sync_n),
    .dac_sdata  (dac_sdata),
    .frame_done (frame_done)
  );

  dac_spi_tx #(.CLK_DIV(1), .GAP_CYCLES(1)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in1),
    .data_valid (data_valid1),
    .data_ready (data_ready1),
    .dac_sclk   (dac_sclk1),
    .dac_sync_n (dac_sync_n1),
    .dac_sdata  (dac_sdata1),
    .frame_done (frame_done1)
  );

  // Link monitor for the default instance: frame start times, words
  // captured on sclk falling edges, frame lengths, frame_done pulses.
  int          cyc = 0;
  logic        p_sync = 1'b1;
  logic        p_sclk = 1'b1;
  logic [15:0] m_sh = '0;
  int          m_nb = 0;
  int          m_low = 0;
  int          fd_cnt = 0;
  int          q_fall[$];
  logic [15:0] q_word[$];
  int          q_low[$];
  int          q_nb[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (p_sync && !dac_sync_n) begin
      q_fall.push_back(cyc);
      m_sh = '0; m_nb = 0; m_low = 0;
    end
    if (!dac_sync_n) begin
      m_low = m_low + 1;
      if (p_sclk && !dac_sclk) begin
        m_sh = {m_sh[14:0], dac_sdata};
        m_nb = m_nb + 1;
      end
    end
    if (!p_sync && dac_sync_n) begin
      q_word.push_back(m_sh);
      q_low.push_back(m_low);
      q_nb.push_back(m_nb);
    end
    if (frame_done) fd_cnt = fd_cnt + 1;
    p_sync = dac_sync_n;
    p_sclk = dac_sclk;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    q_fall.delete(); q_word.delete(); q_low.delete(); q_nb.delete();
    fd_cnt = 0;
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int c = 0; c < budget && q_word.size() < n; c++) tick();
  endtask

  logic [15:0] words[3];
  int          n_acc;
  logic        acc;
  int          low1, bad1, nb1;
  logic [15:0] w1;
  logic        ps1, first1, last1, done1;

  initial begin
    // ---------------- reset state ----------------
    tick();
    check("rst_sclk", dac_sclk, 1);
    check("rst_sync_n", dac_sync_n, 1);
    check("rst_sdata", dac_sdata, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_ready", data_ready, 1);
    check("rst_sync_n_cd1", dac_sync_n1, 1);
    tick();
    reset = 1'b0;
    tick();

    // ---------------- single sample 0xA5C3 ----------------
    clear_mon();
    data_in = 16'hA5C3; data_valid = 1'b1;
    check("t1_ready_before", data_ready, 1);
    tick();                                  // acceptance edge T done
    data_valid = 1'b0;
    check("t1_ready_after_accept", data_ready, 0);
    check("t1_sync_still_high", dac_sync_n, 1);
    tick();                                  // load edge T+1 done
    check("t1_sync_low", dac_sync_n, 0);
    check("t1_bit15", dac_sdata, 1);
    check("t1_sclk_high_c1", dac_sclk, 1);
    check("t1_ready_after_load", data_ready, 1);
    tick();
    check("t1_sclk_high_c2", dac_sclk, 1);
    tick();
    check("t1_sclk_fall", dac_sclk, 0);
    wait_words(1, 300);
    check("t1_nwords", q_word.size(), 1);
    check("t1_word", q_word[0], 16'hA5C3);
    check("t1_low_len", q_low[0], 64);
    check("t1_nbits", q_nb[0], 16);
    // underrun: nothing more arrives
    repeat (100) tick();
    check("t1_frame_done_cnt", fd_cnt, 1);
    check("t1_no_repeat", q_word.size(), 1);
    check("t1_idle_sync", dac_sync_n, 1);
    check("t1_idle_sclk", dac_sclk, 1);
    check("t1_idle_sdata", dac_sdata, 0);

    // ---------------- continuous supply ----------------
    clear_mon();
    words[0] = 16'h1FFF; words[1] = 16'h0000; words[2] = 16'h1FFF;
    n_acc = 0;
    for (int c = 0; c < 400 && n_acc < 3; c++) begin
      data_in = words[n_acc]; data_valid = 1'b1;
      acc = data_ready;
      tick();
      if (acc) begin
        check("t2_ready_low_when_full", data_ready, 0);
        n_acc++;
      end
    end
    data_valid = 1'b0;
    check("t2_accepted", n_acc, 3);
    wait_words(3, 400);
    check("t2_nwords", q_word.size(), 3);
    check("t2_word0", q_word[0], 16'h1FFF);
    check("t2_word1", q_word[1], 16'h0000);
    check("t2_word2", q_word[2], 16'h1FFF);
    check("t2_period01", q_fall[1] - q_fall[0], 68);
    check("t2_period12", q_fall[2] - q_fall[1], 68);
    repeat (20) tick();

    // ---------------- second sample during SHIFT ----------------
    clear_mon();
    data_in = 16'h1234; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (20) tick();
    check("t3_shifting", dac_sync_n, 0);
    check("t3_ready_mid_shift", data_ready, 1);
    data_in = 16'hBEEF; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("t3_ready_after_accept", data_ready, 0);
    wait_words(2, 400);
    check("t3_nwords", q_word.size(), 2);
    check("t3_word0", q_word[0], 16'h1234);
    check("t3_word1", q_word[1], 16'hBEEF);
    check("t3_no_idle_gap", q_fall[1] - q_fall[0], 68);
    repeat (100) tick();
    check("t3_underrun_no_repeat", q_word.size(), 2);
    check("t3_underrun_sync", dac_sync_n, 1);

    // ---------------- reset mid-frame with hold full ----------------
    data_in = 16'h5555; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    data_in = 16'h3333; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("t4_hold_full", data_ready, 0);
    repeat (32) tick();                      // inside bit 7
    check("t4_mid_frame", dac_sync_n, 0);
    #1 reset = 1'b1;
    #1;
    check("t4_rst_sync", dac_sync_n, 1);
    check("t4_rst_sclk", dac_sclk, 1);
    check("t4_rst_sdata", dac_sdata, 0);
    check("t4_rst_ready", data_ready, 1);
    tick();
    reset = 1'b0;
    tick(); tick();
    clear_mon();
    repeat (150) tick();
    check("t4_no_frame", q_word.size(), 0);
    check("t4_idle_sync", dac_sync_n, 1);
    data_in = 16'h0F0F; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    wait_words(1, 300);
    check("t4_new_nwords", q_word.size(), 1);
    check("t4_new_word", q_word[0], 16'h0F0F);

    // ---------------- CLK_DIV=1, GAP_CYCLES=1, 0x8001 ----------------
    data_in1 = 16'h8001; data_valid1 = 1'b1;
    tick();
    data_valid1 = 1'b0;
    check("t5_sync_still_high", dac_sync_n1, 1);
    tick();
    check("t5_sync_low", dac_sync_n1, 0);
    check("t5_sclk_high", dac_sclk1, 1);
    check("t5_bit15", dac_sdata1, 1);
    low1 = 1; bad1 = 0; nb1 = 0; w1 = '0; first1 = 1'b0; last1 = 1'b0; done1 = 1'b0;
    ps1 = dac_sclk1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (dac_sclk1 == ps1) bad1++;
      if (dac_sync_n1) begin
        done1 = frame_done1;
        break;
      end
      low1++;
      if (ps1 && !dac_sclk1) begin
        w1 = {w1[14:0], dac_sdata1};
        nb1++;
        if (nb1 == 1) first1 = dac_sdata1;
        last1 = dac_sdata1;
      end
      ps1 = dac_sclk1;
    end
    check("t5_low_len", low1, 32);
    check("t5_sclk_toggle_errs", bad1, 0);
    check("t5_nbits", nb1, 16);
    check("t5_word", w1, 16'h8001);
    check("t5_first_bit", first1, 1);
    check("t5_last_bit", last1, 1);
    check("t5_frame_done", done1, 1);
    tick();
    check("t5_frame_done_single", frame_done1, 0);
    repeat (5) tick();
    check("t5_idle_sync", dac_sync_n1, 1);
    check("t5_idle_sclk", dac_sclk1, 1);
    check("t5_idle_sdata", dac_sdata1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
